memory_game_ctrl: RTL and testbench
===================================

Name: memory_game_ctrl

Overview:
- Game-logic stage for the two-player 4x4 memory (card-matching) game; sits directly upstream of the VGA board renderer.
- Drives the renderer's cursor index `block` and active-player flag `player`, plus per-card revealed/matched masks.
- Turns debounced push-button levels into card selections and runs turns, match checks, scoring and game end.

Parameters:
- TURN_CYCLES, 250_000_000, clock cycles allowed per turn before forced turn loss (10 s at 25 MHz).
- SHOW_CYCLES, 25_000_000, clock cycles a mismatched pair stays revealed (1 s at 25 MHz).

Ports:
- VGA_CLK_IN  in  1  system clock (same domain as renderer).
- rst  in  1  synchronous, active-high reset.
- btn_next  in  1  debounced level; rising edge advances cursor.
- btn_sel  in  1  debounced level; rising edge selects card at cursor.
- block  out  4  cursor card index 0..15, row-major.
- player  out  1  active player (0/1).
- revealed  out  16  bit i=1: card i face-up, not yet matched.
- matched  out  16  bit i=1: card i permanently matched.
- score0  out  4  pairs won by player 0 (0..8).
- score1  out  4  pairs won by player 1 (0..8).
- game_over  out  1  high in DONE.
- winner  out  2  0=player0, 1=player1, 2=tie; valid only when game_over=1, else 0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: block=0, player=0, revealed=0, matched=0, score0=0, score1=0, game_over=0, winner=0, state=PICK1, timer=0, edge-detect registers=0.
- Edge detection: each button has a registered previous value; an event is current & ~prev, one pulse per press. A button held through reset release produces no event.
- Fixed card layout, ids by index 0..15: 0,1,2,3,4,5,6,7,5,1,6,3,7,0,4,2. Id meanings: 0 purple, 1 celeste, 2 green, 3 red, 4 blue, 5 yellow, 6 orange, 7 gray. Layout is a constant ROM.
- Cursor: a next event in PICK1 or PICK2 sets block=(block+1) mod 16; 15 wraps to 0. Ignored in CHECK and SHOW.
- Simultaneous next and sel in one cycle: sel acts on the pre-increment block, and the increment also applies.
- PICK1: sel with matched[block]=0 sets revealed[block]=1, first=block, goes to PICK2. Sel on a matched card is ignored.
- PICK2: sel with block≠first and matched[block]=0 sets revealed[block]=1, second=block, goes to CHECK. Otherwise ignored.
- CHECK (exactly 1 cycle):
  - If id[first]==id[second]: set both bits in matched, clear both in revealed, increment the active player's score. Go to DONE if matched becomes all ones, else PICK1. Same player keeps the turn; timer=0.
  - If ids differ: go to SHOW, timer=0.
- SHOW: timer increments each cycle. When timer==SHOW_CYCLES-1: revealed=0, player toggles, timer=0, go to PICK1.
- Turn timer: in PICK1/PICK2 the timer increments each cycle; it is reset to 0 only at turn start.
  - When timer==TURN_CYCLES-1: revealed=0, player toggles, timer=0, go to PICK1.
  - A timeout wins over a sel in the same cycle.
- DONE: game_over=1; winner from score compare. The next sel event performs a full restart to reset values. Next events are ignored.
- Width rules: timer is 28 bits and must cover max(TURN_CYCLES, SHOW_CYCLES). Scores saturate logically at 8; no wrap is reachable.
- rst asserted in any state, including mid-SHOW or mid-CHECK, returns all outputs to reset values on the next edge.
- All outputs are registered; there is no combinational path from buttons to outputs.

Optional Feature:
- Macro: SKIP_MATCHED_EN.
- Defined: a next event moves block to the next index after block, mod 16, whose matched bit is 0, searching at most 15 steps. If every other card is matched, block is unchanged.
- Undefined: plain mod-16 increment; the cursor may rest on matched cards, whose sel is ignored.

Test Plan:
- Reset with btn_sel held high, then release rst -> no selection; block=0, revealed=0, state PICK1.
- Cursor at 0, sel; 13 next events, sel (cards 0 and 13, both id 0) -> after CHECK: matched=16'h2001, revealed=0, score0=1, player=0.
- Select 0 then 1 (ids 0 vs 1), SHOW_CYCLES=10 -> revealed=16'h0003 for exactly 10 cycles after CHECK, then revealed=0, player=1.
- TURN_CYCLES=100; select card 4 and wait -> at turn cycle 100, revealed=0, player toggles; a sel in the timeout cycle is dropped.
- Cursor at 15, next event -> block=0. With SKIP_MATCHED_EN and matched=16'h0003 -> block=2.
- Play all 8 pairs, player0 wins 5 -> game_over=1, winner=0, score0=5, score1=3. Next sel -> full reset values.

Source files
------------

// File: rtl/memory_game_ctrl.sv
// memory_game_ctrl: game logic for the two-player 4x4 memory (card-matching) game.
// Turns debounced button levels into cursor moves and card selections, runs turns, match
// checks, scoring and game end. Feeds the VGA board renderer.
//
// Ports:
//   VGA_CLK_IN  system clock (renderer domain)
//   rst         synchronous active-high reset
//   btn_next    debounced level, rising edge advances the cursor
//   btn_sel     debounced level, rising edge selects the card under the cursor
//   block       cursor card index 0..15, row-major
//   player      active player (0/1)
//   revealed    per-card face-up (not yet matched) mask
//   matched     per-card permanently matched mask
//   score0/1    pairs won by each player
//   game_over   high once every pair is matched
//   winner      0=player0, 1=player1, 2=tie (0 unless game_over)
//
// Optional build macro SKIP_MATCHED_EN: the cursor skips over matched cards.
module memory_game_ctrl #(
  parameter int unsigned TURN_CYCLES = 250_000_000,
  parameter int unsigned SHOW_CYCLES = 25_000_000
) (
  input  logic        VGA_CLK_IN,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_sel,
  output logic [3:0]  block,
  output logic        player,
  output logic [15:0] revealed,
  output logic [15:0] matched,
  output logic [3:0]  score0,
  output logic [3:0]  score1,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic [2:0] {StPick1, StPick2, StCheck, StShow, StDone} gameState_e;

  localparam logic [27:0] TurnLast = 28'(TURN_CYCLES - 1);
  localparam logic [27:0] ShowLast = 28'(SHOW_CYCLES - 1);

  // Fixed board layout ROM: card index -> colour id.
  function automatic logic [2:0] cardId(input logic [3:0] idx);
    logic [2:0] id;
    unique case (idx)
      4'd0:  id = 3'd0;  4'd1:  id = 3'd1;  4'd2:  id = 3'd2;  4'd3:  id = 3'd3;
      4'd4:  id = 3'd4;  4'd5:  id = 3'd5;  4'd6:  id = 3'd6;  4'd7:  id = 3'd7;
      4'd8:  id = 3'd5;  4'd9:  id = 3'd1;  4'd10: id = 3'd6;  4'd11: id = 3'd3;
      4'd12: id = 3'd7;  4'd13: id = 3'd0;  4'd14: id = 3'd4;  default: id = 3'd2;
    endcase
    return id;
  endfunction

  function automatic logic [15:0] cardMask(input logic [3:0] idx);
    return 16'd1 << idx;
  endfunction

  gameState_e  stateQ, stateD;
  logic [3:0]  blockQ, blockD, firstQ, firstD, secondQ, secondD;
  logic        playerQ, playerD, gameOverQ, gameOverD;
  logic [15:0] revealedQ, revealedD, matchedQ, matchedD;
  logic [3:0]  score0Q, score0D, score1Q, score1D;
  logic [1:0]  winnerQ, winnerD;
  logic [27:0] timerQ, timerD;
  logic        prevNextQ, prevNextD, prevSelQ, prevSelD;
  // armQ is low for the first cycle out of reset/restart so a button held across it
  // cannot register as a fresh press.
  logic        armQ, armD;
  logic        nextEv, selEv;
  logic [3:0]  cursorNext;

  assign nextEv = armQ & btn_next & ~prevNextQ;
  assign selEv  = armQ & btn_sel & ~prevSelQ;

`ifdef SKIP_MATCHED_EN
  logic       found;
  logic [3:0] cand;
  always_comb begin
    cursorNext = blockQ;
    found      = 1'b0;
    cand       = '0;
    for (int k = 1; k < 16; k++) begin
      cand = blockQ + 4'(k);
      if (!found && !matchedQ[cand]) begin
        cursorNext = cand;
        found      = 1'b1;
      end
    end
  end
`else
  assign cursorNext = blockQ + 4'd1;
`endif

  always_comb begin
    stateD    = stateQ;
    blockD    = blockQ;
    playerD   = playerQ;
    revealedD = revealedQ;
    matchedD  = matchedQ;
    score0D   = score0Q;
    score1D   = score1Q;
    gameOverD = gameOverQ;
    winnerD   = winnerQ;
    firstD    = firstQ;
    secondD   = secondQ;
    timerD    = timerQ;
    prevNextD = btn_next;
    prevSelD  = btn_sel;
    armD      = 1'b1;
    unique case (stateQ)
      StPick1, StPick2: begin
        if (nextEv) blockD = cursorNext;
        if (timerQ == TurnLast) begin
          // Timeout beats any selection arriving in the same cycle.
          revealedD = '0;
          playerD   = ~playerQ;
          timerD    = '0;
          stateD    = StPick1;
        end else begin
          timerD = timerQ + 28'd1;
          if (selEv && !matchedQ[blockQ]) begin
            if (stateQ == StPick1) begin
              revealedD = revealedQ | cardMask(blockQ);
              firstD    = blockQ;
              stateD    = StPick2;
            end else if (blockQ != firstQ) begin
              revealedD = revealedQ | cardMask(blockQ);
              secondD   = blockQ;
              stateD    = StCheck;
            end
          end
        end
      end
      StCheck: begin
        timerD = '0;
        if (cardId(firstQ) == cardId(secondQ)) begin
          matchedD  = matchedQ | cardMask(firstQ) | cardMask(secondQ);
          revealedD = revealedQ & ~(cardMask(firstQ) | cardMask(secondQ));
          if (playerQ) score1D = score1Q + 4'd1;
          else         score0D = score0Q + 4'd1;
          if (&matchedD) begin
            stateD    = StDone;
            gameOverD = 1'b1;
            if (score0D > score1D)      winnerD = 2'd0;
            else if (score1D > score0D) winnerD = 2'd1;
            else                        winnerD = 2'd2;
          end else begin
            stateD = StPick1;
          end
        end else begin
          stateD = StShow;
        end
      end
      StShow: begin
        if (timerQ == ShowLast) begin
          revealedD = '0;
          playerD   = ~playerQ;
          timerD    = '0;
          stateD    = StPick1;
        end else begin
          timerD = timerQ + 28'd1;
        end
      end
      StDone: begin
        if (selEv) begin
          stateD    = StPick1;
          blockD    = '0;
          playerD   = 1'b0;
          revealedD = '0;
          matchedD  = '0;
          score0D   = '0;
          score1D   = '0;
          gameOverD = 1'b0;
          winnerD   = '0;
          firstD    = '0;
          secondD   = '0;
          timerD    = '0;
          prevNextD = 1'b0;
          prevSelD  = 1'b0;
          armD      = 1'b0;
        end
      end
      default: stateD = StPick1;
    endcase
  end

  always_ff @(posedge VGA_CLK_IN) begin
    if (rst) begin
      stateQ    <= StPick1;
      blockQ    <= '0;
      playerQ   <= 1'b0;
      revealedQ <= '0;
      matchedQ  <= '0;
      score0Q   <= '0;
      score1Q   <= '0;
      gameOverQ <= 1'b0;
      winnerQ   <= '0;
      firstQ    <= '0;
      secondQ   <= '0;
      timerQ    <= '0;
      prevNextQ <= 1'b0;
      prevSelQ  <= 1'b0;
      armQ      <= 1'b0;
    end else begin
      stateQ    <= stateD;
      blockQ    <= blockD;
      playerQ   <= playerD;
      revealedQ <= revealedD;
      matchedQ  <= matchedD;
      score0Q   <= score0D;
      score1Q   <= score1D;
      gameOverQ <= gameOverD;
      winnerQ   <= winnerD;
      firstQ    <= firstD;
      secondQ   <= secondD;
      timerQ    <= timerD;
      prevNextQ <= prevNextD;
      prevSelQ  <= prevSelD;
      armQ      <= armD;
    end
  end

  assign block     = blockQ;
  assign player    = playerQ;
  assign revealed  = revealedQ;
  assign matched   = matchedQ;
  assign score0    = score0Q;
  assign score1    = score1Q;
  assign game_over = gameOverQ;
  assign winner    = winnerQ;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl, built with short turn/show timers.
module tb_memory_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_next = 1'b0;
  logic        btn_sel = 1'b0;
  logic [3:0]  block;
  logic        player;
  logic [15:0] revealed, matched;
  logic [3:0]  score0, score1;
  logic        game_over;
  logic [1:0]  winner;

  memory_game_ctrl #(
    .TURN_CYCLES(100),
    .SHOW_CYCLES(10)
  ) dut (
    .VGA_CLK_IN(clk),
    .rst(rst),
    .btn_next(btn_next),
    .btn_sel(btn_sel),
    .block(block),
    .player(player),
    .revealed(revealed),
    .matched(matched),
    .score0(score0),
    .score1(score1),
    .game_over(game_over),
    .winner(winner)
  );

  always #5 clk = ~clk;

  int          nCmp = 0;
  int          nBad = 0;
  int          stepCnt = 0;
  logic [3:0]  expBlock = '0;
  logic [15:0] modelMatched = '0;

  typedef struct {
    logic [3:0]  a;
    logic [3:0]  b;
    logic        isMatch;
    logic        expPlayer;
    logic [15:0] expMatched;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic        over;
    logic [1:0]  win;
  } turn_t;

  turn_t game [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step(input logic n, input logic s);
    @(negedge clk);
    btn_next = n;
    btn_sel  = s;
    stepCnt++;
  endtask

  task automatic doReset(input logic holdSel);
    rst = 1'b1;
    step(1'b0, holdSel);
    step(1'b0, holdSel);
    @(negedge clk);
    rst = 1'b0;
    stepCnt = 0;
    expBlock = '0;
    modelMatched = '0;
  endtask

  task automatic pressSel();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  function automatic logic [3:0] modelNext(input logic [3:0] b, input logic [15:0] m);
    logic [3:0] idx;
    idx = b + 4'd1;
`ifdef SKIP_MATCHED_EN
    for (int k = 1; k < 16; k++) begin
      idx = b + 4'(k);
      if (!m[idx]) return idx;
    end
    return b;
`else
    if (m[idx] === 1'bx) return b;
    return idx;
`endif
  endfunction

  task automatic gotoCard(input logic [3:0] target);
    for (int i = 0; i < 16 && expBlock != target; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      expBlock = modelNext(expBlock, modelMatched);
      check("cursor_step", 32'(block), 32'(expBlock));
    end
    check("cursor_at_target", 32'(block), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //              a     b     match pl  matched    s0 s1 over win
    game[0] = '{4'd0, 4'd13, 1'b1, 1'b0, 16'h2001, 4'd1, 4'd0, 1'b0, 2'd0};
    game[1] = '{4'd1, 4'd9,  1'b1, 1'b0, 16'h2203, 4'd2, 4'd0, 1'b0, 2'd0};
    game[2] = '{4'd2, 4'd15, 1'b1, 1'b0, 16'hA207, 4'd3, 4'd0, 1'b0, 2'd0};
    game[3] = '{4'd3, 4'd11, 1'b1, 1'b0, 16'hAA0F, 4'd4, 4'd0, 1'b0, 2'd0};
    game[4] = '{4'd4, 4'd14, 1'b1, 1'b0, 16'hEA1F, 4'd5, 4'd0, 1'b0, 2'd0};
    game[5] = '{4'd5, 4'd6,  1'b0, 1'b1, 16'hEA1F, 4'd5, 4'd0, 1'b0, 2'd0};
    game[6] = '{4'd5, 4'd8,  1'b1, 1'b1, 16'hEB3F, 4'd5, 4'd1, 1'b0, 2'd0};
    game[7] = '{4'd6, 4'd10, 1'b1, 1'b1, 16'hEF7F, 4'd5, 4'd2, 1'b0, 2'd0};
    game[8] = '{4'd7, 4'd12, 1'b1, 1'b1, 16'hFFFF, 4'd5, 4'd3, 1'b1, 2'd0};

    // Reset with sel held: the held level must not count as a press.
    doReset(1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("rst_block", 32'(block), 32'd0);
    check("rst_player", 32'(player), 32'd0);
    check("rst_revealed", 32'(revealed), 32'd0);
    check("rst_matched", 32'(matched), 32'd0);
    check("rst_scores", {24'd0, score0, score1}, 32'd0);
    check("rst_over_winner", {29'd0, game_over, winner}, 32'd0);
    step(1'b0, 1'b0);
    pressSel();
    check("pick1_after_held_reset", 32'(revealed), 32'h0001);

    // Mismatch 0/1: pair stays up for SHOW_CYCLES after CHECK, then turn passes.
    doReset(1'b0);
    pressSel();
    check("show_first_pick", 32'(revealed), 32'h0001);
    pressSel();
    check("same_card_ignored", 32'(revealed), 32'h0001);
    gotoCard(4'd1);
    pressSel();
    check("show_pair_in_check", 32'(revealed), 32'h0003);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("show_hold", 32'(revealed), 32'h0003);
      check("show_player_hold", 32'(player), 32'd0);
      step(1'b0, 1'b0);
    end
    check("show_end_revealed", 32'(revealed), 32'd0);
    check("show_end_player", 32'(player), 32'd1);
    check("show_end_matched", 32'(matched), 32'd0);

    // Turn timeout at cycle 100, with a sel landing in the timeout cycle.
    doReset(1'b0);
    gotoCard(4'd4);
    pressSel();
    check("to_pick", 32'(revealed), 32'h0010);
    gotoCard(4'd5);
    while (stepCnt < 98) step(1'b0, 1'b0);
    check("to_before", 32'(revealed), 32'h0010);
    check("to_before_player", 32'(player), 32'd0);
    step(1'b0, 1'b1);
    check("to_last_cycle", 32'(revealed), 32'h0010);
    step(1'b0, 1'b0);
    check("to_revealed", 32'(revealed), 32'd0);
    check("to_player", 32'(player), 32'd1);
    check("to_block", 32'(block), 32'd5);
    pressSel();
    check("to_new_turn_pick1", 32'(revealed), 32'h0020);

    // Cursor wrap 15 -> 0.
    gotoCard(4'd15);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("wrap_15_to_0", 32'(block), 32'd0);

    // Full game: player0 takes 5 pairs, misses, player1 takes 3.
    doReset(1'b0);
    for (int i = 0; i < 9; i++) begin
      gotoCard(game[i].a);
      pressSel();
      check("game_first", 32'(revealed), 32'(16'd1 << game[i].a));
      gotoCard(game[i].b);
      pressSel();
      check("game_pair", 32'(revealed), 32'((16'd1 << game[i].a) | (16'd1 << game[i].b)));
      step(1'b0, 1'b0);
      if (!game[i].isMatch) begin
        check("game_show_pair", 32'(revealed), 32'((16'd1 << game[i].a) | (16'd1 << game[i].b)));
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
      end
      check("game_revealed", 32'(revealed), 32'd0);
      check("game_player", 32'(player), 32'(game[i].expPlayer));
      check("game_matched", 32'(matched), 32'(game[i].expMatched));
      check("game_score0", 32'(score0), 32'(game[i].s0));
      check("game_score1", 32'(score1), 32'(game[i].s1));
      check("game_over", 32'(game_over), 32'(game[i].over));
      check("game_winner", 32'(winner), 32'(game[i].win));
      modelMatched = game[i].expMatched;
      if (i == 0) begin
        pressSel();
        check("sel_on_matched_ignored", 32'(revealed), 32'd0);
      end
    end

    // DONE: next ignored, sel restarts everything.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("done_next_ignored", 32'(block), 32'd12);
    check("done_still_over", 32'(game_over), 32'd1);
    pressSel();
    check("restart_block", 32'(block), 32'd0);
    check("restart_player", 32'(player), 32'd0);
    check("restart_revealed", 32'(revealed), 32'd0);
    check("restart_matched", 32'(matched), 32'd0);
    check("restart_scores", {24'd0, score0, score1}, 32'd0);
    check("restart_over_winner", {29'd0, game_over, winner}, 32'd0);
    step(1'b0, 1'b0);
    pressSel();
    check("restart_pick1", 32'(revealed), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
